// File: rtl/bin_to_bcd_if.sv
// Handshake and result bundle between the calculator core and the BCD converter.
// The master drives start/bin_in; the slave (the converter) returns status and digits.
interface bin_to_bcd_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       out1;
  logic [3:0]       out2;
  logic [3:0]       out3;
  logic [3:0]       out4;

  modport master (
    output start, bin_in,
    input  busy, done, ovf, out1, out2, out3, out4
  );

  modport slave (
    input  start, bin_in,
    output busy, done, ovf, out1, out2, out3, out4
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per clock, results held
// in output registers so the display only ever sees complete values.
module bin_to_bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  bin_to_bcd_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [15:0]      bcd_adj;

  // Add-3 correction on every nibble in parallel, applied before each shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    count_d    = count_q;
    ovf_pend_d = ovf_pend_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d    = bus.bin_in;
          bcd_d      = 16'd0;
          count_d    = 4'(WIDTH);
          ovf_pend_d = (32'(bus.bin_in) > 32'd9999);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Carry out of the thousands nibble is dropped; overflow is handled by ovf_pend.
        {bcd_d, shift_d} = {bcd_adj[14:0], shift_q, 1'b0};
        count_d          = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        digits_d = ovf_pend_q ? 16'h9999 : bcd_q;
        ovf_d    = ovf_pend_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bcd_q      <= 16'd0;
      count_q    <= 4'd0;
      ovf_pend_q <= 1'b0;
      digits_q   <= 16'd0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      count_q    <= count_d;
      ovf_pend_q <= ovf_pend_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.out1 = digits_q[15:12];
  assign bus.out2 = digits_q[11:8];
  assign bus.out3 = digits_q[7:4];
  assign bus.out4 = digits_q[3:0];

endmodule
